// File: rtl/pixel_pack_fifo.sv
// pixel_pack_fifo
//   Packs 8-bit pixel samples into little-endian 32-bit words and buffers them
//   in a synchronous FIFO. The first pixel of a word lands in bits [7:0]. An
//   end-of-frame pulse flushes a partial word, with its unfilled upper bytes
//   set to zero.
//
//   Stage p0 : packer (byte index, holding register, packed-word register)
//   Stage p1 : FIFO RAM, pointers, word count, registered status flags
//
// Ports
//   clk            rising-edge system clock
//   reset          asynchronous active-high reset (packer, pointers, flags)
//   write_enable   write_data carries a valid pixel this cycle
//   write_data     8-bit pixel sample
//   frame_done     end-of-frame pulse; flushes a partial word
//   read_enable    pop one word (ignored while empty)
//   clear_overflow clears the sticky overflow flag
//   read_data      last popped word (held between reads)
//   data_valid     one-cycle pulse when read_data is freshly popped
//   empty/afull/full  word-count status (registered)
//   overflow       sticky: a word was dropped because the FIFO was full
//   word_count     number of stored words
module pixel_pack_fifo #(
  parameter int DEPTH        = 256,
  parameter int AFULL_THRESH = 192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [7:0]               write_data,
  input  logic                     frame_done,
  input  logic                     read_enable,
  input  logic                     clear_overflow,
  output logic [31:0]              read_data,
  output logic                     data_valid,
  output logic                     empty,
  output logic                     afull,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_W = AFULL_THRESH[AW:0];

  // Insert a byte at position idx of the partially built word; bytes above
  // idx are forced to zero so stale holding-register contents never leak.
  function automatic logic [31:0] pack_byte(input logic [23:0] h,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
    case (idx)
      2'd0:    pack_byte = {24'h0, b};
      2'd1:    pack_byte = {16'h0, b, h[7:0]};
      2'd2:    pack_byte = {8'h0, b, h[15:0]};
      default: pack_byte = {b, h};
    endcase
  endfunction

  // Partial word holding idx bytes, upper bytes zero-padded.
  function automatic logic [31:0] pad_word(input logic [23:0] h,
                                           input logic [1:0]  idx);
    case (idx)
      2'd0:    pad_word = 32'h0;
      2'd1:    pad_word = {24'h0, h[7:0]};
      2'd2:    pad_word = {16'h0, h[15:0]};
      default: pad_word = {8'h0, h};
    endcase
  endfunction

  logic [1:0]    bidx;
  logic [23:0]   hold;
  logic [1:0]    bidx_adv;
  logic [31:0]   merged;
  logic          push_c;

  logic          vld_p0;
  logic [31:0]   word_p0;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          can_pop;
  logic          do_push;
  logic          drop;
  logic [AW:0]   count_nxt;

  // The incoming byte is absorbed first; a flush then applies to the result,
  // so a byte that completes the word yields exactly one push.
  always_comb begin
    bidx_adv = bidx;
    merged   = pad_word(hold, bidx);
    if (write_enable) begin
      bidx_adv = bidx + 2'd1;
      merged   = pack_byte(hold, bidx, write_data);
    end
    push_c = (write_enable && (bidx == 2'd3)) ||
             (frame_done && (bidx_adv != 2'd0));
  end

  // ---- stage p0: packer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bidx   <= 2'd0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= push_c;
      bidx   <= push_c ? 2'd0 : bidx_adv;
    end
  end

  always_ff @(posedge clk) begin
    if (write_enable) hold <= merged[23:0];
    if (push_c)       word_p0 <= merged;
  end

  // ---- stage p1: FIFO ----
  // A pop on an empty FIFO is ignored; a push into a full FIFO proceeds only
  // when a pop frees a slot in the same cycle.
  always_comb begin
    can_pop   = read_enable && (word_count != '0);
    do_push   = vld_p0 && ((word_count != DEPTH_W) || can_pop);
    drop      = vld_p0 && (word_count == DEPTH_W) && !can_pop;
    count_nxt = word_count;
    if (do_push && !can_pop)      count_nxt = word_count + 1'b1;
    else if (!do_push && can_pop) count_nxt = word_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= word_p0;
  end

  // When full with simultaneous push and pop, wr_ptr == rd_ptr: the read
  // returns the old (oldest) word because the RAM write is non-blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 32'h0;
    end else if (can_pop) begin
      read_data <= mem[rd_ptr];
    end
  end

  // Flags come from the next-state count so they move with word_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (can_pop) rd_ptr <= rd_ptr + 1'b1;
      word_count <= count_nxt;
      empty      <= (count_nxt == '0);
      afull      <= (count_nxt >= AFULL_W);
      full       <= (count_nxt == DEPTH_W);
      data_valid <= can_pop;
      // Set has priority over clear.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
